// File: rtl/ip_codma_crc_engine.sv
// CRC-32 (MSB-first, non-reflected) over up to NUM_WORDS snapshotted words, one word per clock.
// Latency: start at T with N words -> crc_complete_flag_o in T+N+1, crc_output_o updated from T+N+2.
// No backpressure: start_i/clear_i while busy_o are dropped; stop_i aborts back to INIT.
module ip_codma_crc_engine #(
  parameter logic [31:0] POLY      = 32'h04C1_1DB7,
  parameter logic [31:0] INIT      = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT   = 32'hFFFF_FFFF,
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic                       clear_i,
  input  logic                       stop_i,
  input  logic [3:0]                 word_count_i,
  input  logic [NUM_WORDS-1:0][31:0] data_reg_i,
  output logic                       busy_o,
  output logic                       crc_complete_flag_o,
  output logic [31:0]                crc_output_o
);

  localparam int unsigned IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [3:0]  MAX_CNT = 4'(NUM_WORDS);

  typedef enum logic [1:0] {
    CRC_IDLE = 2'd0,
    CRC_RUN  = 2'd1,
    CRC_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [31:0]                crc_q, crc_d;
  logic [31:0]                out_q, out_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [3:0]                 cnt_clamped;
  logic [NUM_WORDS-1:0][31:0] data_q;
  logic                       load;
  logic                       flag;

  // One full word through the serial LFSR, bit 31 first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  assign cnt_clamped = (word_count_i > MAX_CNT) ? MAX_CNT : word_count_i;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    load    = 1'b0;
    flag    = 1'b0;
    case (state_q)
      CRC_IDLE: begin
        if (start_i) begin
          load  = 1'b1;
          idx_d = '0;
          cnt_d = cnt_clamped;
          if (clear_i) begin
            crc_d = INIT;
          end
          state_d = (cnt_clamped == 4'd0) ? CRC_DONE : CRC_RUN;
        end else if (clear_i) begin
          crc_d = INIT;
        end
      end
      CRC_RUN: begin
        // Abort wins over finishing the last word.
        if (stop_i) begin
          state_d = CRC_IDLE;
          crc_d   = INIT;
        end else begin
          crc_d = crc_step(crc_q, data_q[idx_q]);
          idx_d = idx_q + IDX_W'(1);
          if (4'(idx_q) == cnt_q - 4'd1) begin
            state_d = CRC_DONE;
          end
        end
      end
      CRC_DONE: begin
        state_d = CRC_IDLE;
        if (stop_i) begin
          crc_d = INIT;
        end else begin
          flag  = 1'b1;
          out_d = crc_q ^ XOR_OUT;
        end
      end
      default: begin
        state_d = CRC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= CRC_IDLE;
      crc_q   <= INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= INIT ^ XOR_OUT;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Snapshot only; contents are don't-care until the next accepted start.
  always_ff @(posedge clk_i) begin
    if (load) begin
      data_q <= data_reg_i;
    end
  end

  assign busy_o              = (state_q != CRC_IDLE);
  assign crc_complete_flag_o = flag;
  assign crc_output_o        = out_q;

endmodule

// File: tb/tb_ip_codma_crc_engine.sv
// Randomized scoreboard bench for ip_codma_crc_engine: two instances (zero-seed and default params)
// share stimulus; expected CRCs come from polynomial long division over the accumulated word stream.
module tb_ip_codma_crc_engine;

  localparam logic [31:0] P  = 32'h04C1_1DB7;
  localparam logic [31:0] ZI = 32'h0000_0000;
  localparam logic [31:0] ZX = 32'h0000_0000;
  localparam logic [31:0] DI = 32'hFFFF_FFFF;
  localparam logic [31:0] DX = 32'hFFFF_FFFF;

  typedef struct {
    int          fcyc;
    logic [31:0] z;
    logic [31:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             stop = 1'b0;
  logic [3:0]       word_count = 4'd0;
  logic [7:0][31:0] data_reg = '0;
  logic             busy_z, flag_z, busy_d, flag_d;
  logic [31:0]      out_z, out_d;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  exp_t        sb[$];
  logic [31:0] stream[$];
  int          lo = 1, hi = 0, rst_cyc = -1;
  logic [31:0] eo_z = ZI ^ ZX, eo_d = DI ^ DX, pz, pd;
  bit          upd_pend = 1'b0;
  bit          ef, eb;

  ip_codma_crc_engine #(.INIT(ZI), .XOR_OUT(ZX)) dut_z (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .clear_i(clear), .stop_i(stop),
    .word_count_i(word_count), .data_reg_i(data_reg),
    .busy_o(busy_z), .crc_complete_flag_o(flag_z), .crc_output_o(out_z));

  ip_codma_crc_engine dut_d (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .clear_i(clear), .stop_i(stop),
    .word_count_i(word_count), .data_reg_i(data_reg),
    .busy_o(busy_d), .crc_complete_flag_o(flag_d), .crc_output_o(out_d));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Remainder of (M * x^32 + init * x^len) mod G, with M the whole word stream, MSB first.
  function automatic logic [31:0] model_crc(input logic [31:0] s[$], input logic [31:0] init);
    bit          b[];
    int          len;
    logic [31:0] r;
    if (s.size() == 0) return init;
    len = s.size() * 32;
    b = new[len + 32];
    for (int w = 0; w < s.size(); w++)
      for (int k = 0; k < 32; k++) b[w*32 + k] = s[w][31-k];
    for (int k = 0; k < 32; k++) b[k] ^= init[31-k];
    for (int k = 0; k < 32; k++) b[len + k] = 1'b0;
    for (int i = 0; i < len; i++)
      if (b[i]) for (int j = 0; j < 32; j++) b[i+1+j] ^= P[31-j];
    for (int k = 0; k < 32; k++) r[31-k] = b[len + k];
    return r;
  endfunction

  function automatic logic [7:0][31:0] rw();
    logic [7:0][31:0] w;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start in the current (idle) cycle and post its expected result.
  task automatic do_start(input int n, input logic [7:0][31:0] w, input bit clr);
    exp_t e;
    int   nn;
    nn = (n > 8) ? 8 : n;
    start = 1'b1;
    clear = clr;
    word_count = 4'(n);
    data_reg = w;
    if (clr) stream.delete();
    for (int i = 0; i < nn; i++) stream.push_back(w[i]);
    e.fcyc = cyc + nn + 1;
    e.z = model_crc(stream, ZI) ^ ZX;
    e.d = model_crc(stream, DI) ^ DX;
    sb.push_back(e);
    lo = cyc + 1;
    hi = cyc + nn + 1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    data_reg = rw();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy_z && !busy_d) return;
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle cyc=%0d got=busy expected=idle within 40 cycles", cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == rst_cyc) begin
        eo_z = ZI ^ ZX;
        eo_d = DI ^ DX;
        upd_pend = 1'b0;
      end
      if (upd_pend) begin
        eo_z = pz;
        eo_d = pd;
        upd_pend = 1'b0;
      end
      ef = (sb.size() > 0) && (sb[0].fcyc == cyc);
      eb = (cyc >= lo) && (cyc <= hi);
      chk("flag_z", 32'(flag_z), 32'(ef));
      chk("flag_d", 32'(flag_d), 32'(ef));
      chk("busy_z", 32'(busy_z), 32'(eb));
      chk("busy_d", 32'(busy_d), 32'(eb));
      chk("out_z", out_z, eo_z);
      chk("out_d", out_d, eo_d);
      if (ef) begin
        pz = sb[0].z;
        pd = sb[0].d;
        upd_pend = 1'b1;
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0][31:0] w;
    logic [31:0]      fresh[$];
    int               n;

    tick();
    tick();
    mon_en = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    // Single word 1 from a zero seed yields the polynomial itself.
    w = '0;
    w[0] = 32'h0000_0001;
    do_start(1, w, 1'b0);
    wait_idle();
    chk("t1_out_z", out_z, 32'h04C1_1DB7);

    w[0] = 32'h0;
    w[1] = 32'h1;
    do_start(2, w, 1'b1);
    wait_idle();
    chk("t2_out_z", out_z, 32'h04C1_1DB7);
    do_start(0, rw(), 1'b0);
    wait_idle();
    chk("t2_cnt0_out_z", out_z, 32'h04C1_1DB7);

    // Full bursts accumulating across two starts, then a clamped count.
    do_start(8, rw(), 1'b1);
    wait_idle();
    do_start(8, rw(), 1'b0);
    wait_idle();
    do_start(12, rw(), 1'b0);
    wait_idle();

    // Lone clear, then an empty run reports the seed.
    clear = 1'b1;
    stream.delete();
    tick();
    clear = 1'b0;
    do_start(0, rw(), 1'b0);
    wait_idle();

    // Abort in the fourth RUN cycle, then a one-word run from INIT.
    do_start(8, rw(), 1'b1);
    tick();
    tick();
    tick();
    stop = 1'b1;
    stream.delete();
    sb.delete();
    hi = cyc;
    tick();
    stop = 1'b0;
    do_start(1, rw(), 1'b0);
    wait_idle();

    // start/clear while busy are dropped.
    do_start(8, rw(), 1'b0);
    tick();
    clear = 1'b1;
    tick();
    start = 1'b1;
    clear = 1'b0;
    word_count = 4'd3;
    data_reg = rw();
    tick();
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a run.
    do_start(8, rw(), 1'b1);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    stream.delete();
    sb.delete();
    hi = cyc;
    rst_cyc = cyc + 1;
    tick();
    reset_n = 1'b1;
    tick();

    // clear+start after a prior run must equal a fresh-from-INIT result.
    do_start(3, rw(), 1'b0);
    wait_idle();
    w = rw();
    do_start(5, w, 1'b1);
    wait_idle();
    tick();
    fresh.delete();
    for (int i = 0; i < 5; i++) fresh.push_back(w[i]);
    chk("t6_fresh_d", out_d, model_crc(fresh, DI) ^ DX);
    chk("t6_fresh_z", out_z, model_crc(fresh, ZI) ^ ZX);

    // Random back-to-back runs with occasional clears and gaps.
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, 15);
      do_start(n, rw(), ($urandom_range(0, 3) == 0));
      wait_idle();
      if ($urandom_range(0, 2) == 0) tick();
    end

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
